// File: rtl/video_ctrl_regs_if.sv
// rtl/video_ctrl_regs_if.sv - CPU peripheral bus bundle for the video control registers
interface video_ctrl_regs_if;
    logic       i_cs;
    logic       i_stb;
    logic       i_we;
    logic [3:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_data_ready;

    modport slave (
        input  i_cs, i_stb, i_we, i_addr, i_data,
        output o_data, o_data_ready
    );

    modport master (
        output i_cs, i_stb, i_we, i_addr, i_data,
        input  o_data, o_data_ready
    );
endinterface

// File: rtl/video_ctrl_regs.sv
// rtl/video_ctrl_regs.sv - video control registers: double-buffered colours, frame counter, line/vblank interrupts
module video_ctrl_regs #(
    parameter int          H_LAST   = 639,
    parameter int          V_LAST   = 479,
    parameter logic [11:0] FG_RESET = 12'hFFF,
    parameter logic [11:0] BG_RESET = 12'h000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    video_ctrl_regs_if.slave         bus,
    input  logic [9:0]               i_hcount,
    input  logic [8:0]               i_vcount,
    output logic [11:0]              o_fg_color,
    output logic [11:0]              o_bg_color,
    output logic                     o_irq
);
    localparam logic [9:0] H_LAST_V = 10'(H_LAST);
    localparam logic [8:0] V_LAST_V = 9'(V_LAST);

    localparam logic [3:0] A_FG_L    = 4'd0;
    localparam logic [3:0] A_FG_H    = 4'd1;
    localparam logic [3:0] A_BG_L    = 4'd2;
    localparam logic [3:0] A_BG_H    = 4'd3;
    localparam logic [3:0] A_CTRL    = 4'd4;
    localparam logic [3:0] A_STATUS  = 4'd5;
    localparam logic [3:0] A_LCMP_L  = 4'd6;
    localparam logic [3:0] A_LCMP_H  = 4'd7;
    localparam logic [3:0] A_FRAME_L = 4'd8;
    localparam logic [3:0] A_FRAME_H = 4'd9;
    localparam logic [3:0] A_SCRATCH = 4'd10;

    logic        r_stb_q;
    logic        r_ready;
    logic [7:0]  r_rdata;
    logic [11:0] r_sh_fg, r_sh_bg, r_live_fg, r_live_bg;
    logic [2:0]  r_ctrl;
    logic        r_vblank_pend, r_line_pend;
    logic [8:0]  r_lcmp;
    logic [15:0] r_frame;
    logic [7:0]  r_frame_hi_snap;
    logic [7:0]  r_scratch;
    logic        r_irq;

    logic        w_accept, w_wr, w_rd;
    logic        w_frame_evt, w_line_evt, w_in_vblank;
    logic [11:0] w_sh_fg_nxt, w_sh_bg_nxt, w_live_fg_nxt, w_live_bg_nxt;
    logic [15:0] w_frame_nxt;
    logic        w_vblank_pend_nxt, w_line_pend_nxt;
    logic [7:0]  w_rdata;

    // Only a rising strobe counts, so a held strobe can never repeat a side effect.
    assign w_accept    = bus.i_stb & ~r_stb_q & bus.i_cs;
    assign w_wr        = w_accept & bus.i_we;
    assign w_rd        = w_accept & ~bus.i_we;
    assign w_frame_evt = (i_hcount == H_LAST_V) && (i_vcount == V_LAST_V);
    assign w_line_evt  = (i_hcount == H_LAST_V) && (i_vcount == r_lcmp);
    assign w_in_vblank = i_vcount > V_LAST_V;

    always_comb begin
        w_sh_fg_nxt   = r_sh_fg;
        w_sh_bg_nxt   = r_sh_bg;
        w_live_fg_nxt = r_live_fg;
        w_live_bg_nxt = r_live_bg;
        if (w_wr) begin
            case (bus.i_addr)
                A_FG_L: w_sh_fg_nxt[7:0]  = bus.i_data;
                A_FG_H: w_sh_fg_nxt[11:8] = bus.i_data[3:0];
                A_BG_L: w_sh_bg_nxt[7:0]  = bus.i_data;
                A_BG_H: w_sh_bg_nxt[11:8] = bus.i_data[3:0];
                default: ;
            endcase
        end
        // Commit copies the post-write shadow, so a write landing on the commit edge is not lost.
        if (w_frame_evt) begin
            w_live_fg_nxt = w_sh_fg_nxt;
            w_live_bg_nxt = w_sh_bg_nxt;
        end else if (w_wr && r_ctrl[2]) begin
            case (bus.i_addr)
                A_FG_L: w_live_fg_nxt[7:0]  = bus.i_data;
                A_FG_H: w_live_fg_nxt[11:8] = bus.i_data[3:0];
                A_BG_L: w_live_bg_nxt[7:0]  = bus.i_data;
                A_BG_H: w_live_bg_nxt[11:8] = bus.i_data[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_vblank_pend_nxt = r_vblank_pend;
        w_line_pend_nxt   = r_line_pend;
        if (w_wr && bus.i_addr == A_STATUS) begin
            if (bus.i_data[0]) w_vblank_pend_nxt = 1'b0;
            if (bus.i_data[1]) w_line_pend_nxt   = 1'b0;
        end
        if (w_frame_evt) w_vblank_pend_nxt = 1'b1;
        if (w_line_evt)  w_line_pend_nxt   = 1'b1;
    end

    always_comb begin
        w_frame_nxt = r_frame + {15'd0, w_frame_evt};
        if (w_wr && bus.i_addr == A_FRAME_L) w_frame_nxt[7:0]  = bus.i_data;
        if (w_wr && bus.i_addr == A_FRAME_H) w_frame_nxt[15:8] = bus.i_data;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (bus.i_addr)
            A_FG_L:    w_rdata = r_sh_fg[7:0];
            A_FG_H:    w_rdata = {4'h0, r_sh_fg[11:8]};
            A_BG_L:    w_rdata = r_sh_bg[7:0];
            A_BG_H:    w_rdata = {4'h0, r_sh_bg[11:8]};
            A_CTRL:    w_rdata = {5'd0, r_ctrl};
            A_STATUS:  w_rdata = {5'd0, w_in_vblank, r_line_pend, r_vblank_pend};
            A_LCMP_L:  w_rdata = r_lcmp[7:0];
            A_LCMP_H:  w_rdata = {7'd0, r_lcmp[8]};
            A_FRAME_L: w_rdata = r_frame[7:0];
            A_FRAME_H: w_rdata = r_frame_hi_snap;
            A_SCRATCH: w_rdata = r_scratch;
            default:   w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stb_q         <= 1'b0;
            r_ready         <= 1'b0;
            r_rdata         <= 8'h00;
            r_sh_fg         <= FG_RESET;
            r_sh_bg         <= BG_RESET;
            r_live_fg       <= FG_RESET;
            r_live_bg       <= BG_RESET;
            r_ctrl          <= 3'd0;
            r_vblank_pend   <= 1'b0;
            r_line_pend     <= 1'b0;
            r_lcmp          <= 9'd0;
            r_frame         <= 16'd0;
            r_frame_hi_snap <= 8'h00;
            r_scratch       <= 8'h00;
            r_irq           <= 1'b0;
        end else begin
            r_stb_q <= bus.i_stb;
            if (w_accept)
                r_ready <= 1'b1;
            else if (!bus.i_stb || !bus.i_cs)
                r_ready <= 1'b0;
            if (w_rd) begin
                r_rdata <= w_rdata;
                if (bus.i_addr == A_FRAME_L) r_frame_hi_snap <= r_frame[15:8];
            end
            if (w_wr) begin
                case (bus.i_addr)
                    A_CTRL:    r_ctrl         <= bus.i_data[2:0];
                    A_LCMP_L:  r_lcmp[7:0]    <= bus.i_data;
                    A_LCMP_H:  r_lcmp[8]      <= bus.i_data[0];
                    A_SCRATCH: r_scratch      <= bus.i_data;
                    default: ;
                endcase
            end
            r_sh_fg       <= w_sh_fg_nxt;
            r_sh_bg       <= w_sh_bg_nxt;
            r_live_fg     <= w_live_fg_nxt;
            r_live_bg     <= w_live_bg_nxt;
            r_vblank_pend <= w_vblank_pend_nxt;
            r_line_pend   <= w_line_pend_nxt;
            r_frame       <= w_frame_nxt;
            r_irq         <= (r_vblank_pend & r_ctrl[0]) | (r_line_pend & r_ctrl[1]);
        end
    end

    assign bus.o_data       = r_rdata;
    assign bus.o_data_ready = r_ready;
    assign o_fg_color       = r_live_fg;
    assign o_bg_color       = r_live_bg;
    assign o_irq            = r_irq;
endmodule

// File: tb/tb_video_ctrl_regs.sv
// tb/tb_video_ctrl_regs.sv - self-checking bench for video_ctrl_regs
module tb_video_ctrl_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount;
    logic [8:0]  vcount;
    logic [11:0] fg, bg;
    logic        irq;
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  v_idle;

    video_ctrl_regs_if bif ();

    video_ctrl_regs dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bif.slave),
        .i_hcount   (hcount),
        .i_vcount   (vcount),
        .o_fg_color (fg),
        .o_bg_color (bg),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] a;
        logic       we;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[25];

    // Transaction-level reference state for the random phase
    logic [11:0] m_sh_fg, m_sh_bg, m_live_fg, m_live_bg;
    logic [2:0]  m_ctrl;
    logic        m_vp, m_lp;
    logic [8:0]  m_lcmp;
    logic [15:0] m_frame;
    logic [7:0]  m_snap, m_scr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ev < 0: no event; otherwise hcount=639 and vcount=ev during the accept cycle
    task automatic bus(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input int ev, input logic cs,
                       output logic [7:0] rd, output logic irq_r);
        int n;
        @(posedge clk); #1;
        bif.i_cs = cs; bif.i_stb = 1'b1; bif.i_we = we; bif.i_addr = a; bif.i_data = d;
        if (ev >= 0) begin hcount = 10'd639; vcount = 9'(ev); end
        n = 0;
        do begin
            @(posedge clk); #1;
            hcount = 10'd0; vcount = v_idle;
            n++;
        end while (!bif.o_data_ready && n < 8);
        chk(cs ? "bus_ready" : "nocs_ready", {31'd0, bif.o_data_ready}, {31'd0, cs});
        rd = bif.o_data;
        irq_r = irq;
        bif.i_stb = 1'b0; bif.i_cs = 1'b0;
        @(posedge clk); #1;
        chk("ready_drop", {31'd0, bif.o_data_ready}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] rd; logic ir;
        bus(1'b1, a, d, -1, 1'b1, rd, ir);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] rd; logic ir;
        bus(1'b0, a, 8'h00, -1, 1'b1, rd, ir);
        chk(name, {24'd0, rd}, {24'd0, exp});
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1;
        hcount = 10'd639; vcount = 9'd479;
        @(posedge clk); #1;
        hcount = 10'd0; vcount = v_idle;
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'd0:  return m_sh_fg[7:0];
            4'd1:  return {4'h0, m_sh_fg[11:8]};
            4'd2:  return m_sh_bg[7:0];
            4'd3:  return {4'h0, m_sh_bg[11:8]};
            4'd4:  return {5'd0, m_ctrl};
            4'd5:  return {6'd0, m_lp, m_vp};
            4'd6:  return m_lcmp[7:0];
            4'd7:  return {7'd0, m_lcmp[8]};
            4'd8:  return m_frame[7:0];
            4'd9:  return m_snap;
            4'd10: return m_scr;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'd0: begin m_sh_fg[7:0] = d;       if (m_ctrl[2]) m_live_fg[7:0]  = d;      end
            4'd1: begin m_sh_fg[11:8] = d[3:0]; if (m_ctrl[2]) m_live_fg[11:8] = d[3:0]; end
            4'd2: begin m_sh_bg[7:0] = d;       if (m_ctrl[2]) m_live_bg[7:0]  = d;      end
            4'd3: begin m_sh_bg[11:8] = d[3:0]; if (m_ctrl[2]) m_live_bg[11:8] = d[3:0]; end
            4'd4: m_ctrl = d[2:0];
            4'd5: begin if (d[0]) m_vp = 1'b0; if (d[1]) m_lp = 1'b0; end
            4'd6: m_lcmp[7:0] = d;
            4'd7: m_lcmp[8] = d[0];
            4'd8: m_frame[7:0] = d;
            4'd9: m_frame[15:8] = d;
            4'd10: m_scr = d;
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0] rd;
        logic       ir;
        int         op;
        logic [3:0] a;
        logic [7:0] d;

        rst = 1'b1; hcount = 10'd0; vcount = 9'd0; v_idle = 9'd0;
        bif.i_cs = 1'b0; bif.i_stb = 1'b0; bif.i_we = 1'b0; bif.i_addr = 4'd0; bif.i_data = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_fg", {20'd0, fg}, 32'hFFF);
        chk("rst_bg", {20'd0, bg}, 32'h000);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ready", {31'd0, bif.o_data_ready}, 32'd0);

        for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 1'b0, 8'h00, 8'h00};
        tbl[0].exp = 8'hFF;
        tbl[1].exp = 8'h0F;
        tbl[16] = '{4'd10, 1'b1, 8'hA5, 8'hA5};
        tbl[17] = '{4'd7,  1'b1, 8'hFF, 8'h01};
        tbl[18] = '{4'd7,  1'b1, 8'h00, 8'h00};
        tbl[19] = '{4'd3,  1'b1, 8'hFF, 8'h0F};
        tbl[20] = '{4'd3,  1'b1, 8'h00, 8'h00};
        tbl[21] = '{4'd12, 1'b1, 8'hFF, 8'h00};
        tbl[22] = '{4'd4,  1'b1, 8'hFF, 8'h07};
        tbl[23] = '{4'd5,  1'b1, 8'hFF, 8'h00};
        tbl[24] = '{4'd4,  1'b1, 8'h00, 8'h00};
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
            rd_chk($sformatf("tbl%0d_a%0d", i, tbl[i].a), tbl[i].a, tbl[i].exp);
        end
        chk("tbl_bg_live", {20'd0, bg}, 32'h000);

        // Shadow colour commits only at end of frame; vblank interrupt
        wr(4'd4, 8'h01);
        wr(4'd0, 8'h34);
        wr(4'd1, 8'h02);
        chk("fg_before_commit", {20'd0, fg}, 32'hFFF);
        @(posedge clk); #1;
        hcount = 10'd639; vcount = 9'd479;
        chk("fg_on_evt_cycle", {20'd0, fg}, 32'hFFF);
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 9'd480; v_idle = 9'd480;
        chk("fg_committed", {20'd0, fg}, 32'h234);
        rd_chk("status_vblank", 4'd5, 8'h05);
        chk("irq_vblank", {31'd0, irq}, 32'd1);
        bus(1'b1, 4'd5, 8'h01, -1, 1'b1, rd, ir);
        chk("irq_at_clear_ready", {31'd0, ir}, 32'd1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        v_idle = 9'd0; vcount = 9'd0;

        // Line compare interrupt and W1C colliding with set
        wr(4'd6, 8'd100);
        wr(4'd7, 8'd0);
        wr(4'd4, 8'h02);
        chk("irq_before_line", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        hcount = 10'd639; vcount = 9'd100;
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 9'd0;
        chk("irq_line_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_line", {31'd0, irq}, 32'd1);
        bus(1'b1, 4'd5, 8'h02, 100, 1'b1, rd, ir);
        rd_chk("line_set_wins", 4'd5, 8'h02);
        chk("irq_line_held", {31'd0, irq}, 32'd1);
        bus(1'b1, 4'd1, 8'h0C, 479, 1'b1, rd, ir);
        chk("fg_write_on_commit", {20'd0, fg}, 32'hC34);
        rd_chk("status_both", 4'd5, 8'h03);
        wr(4'd5, 8'h03);
        rd_chk("status_clr", 4'd5, 8'h00);
        chk("irq_all_clear", {31'd0, irq}, 32'd0);

        // Immediate mode
        wr(4'd4, 8'h04);
        wr(4'd2, 8'h5A);
        chk("bg_immediate_l", {20'd0, bg}, 32'h05A);
        wr(4'd3, 8'h07);
        chk("bg_immediate_h", {20'd0, bg}, 32'h75A);
        wr(4'd4, 8'h00);

        // Frame counter snapshot
        wr(4'd8, 8'hFF);
        wr(4'd9, 8'h00);
        rd_chk("frame_l_ff", 4'd8, 8'hFF);
        pulse_frame();
        rd_chk("frame_h_snap", 4'd9, 8'h00);
        rd_chk("frame_l_00", 4'd8, 8'h00);
        rd_chk("frame_h_01", 4'd9, 8'h01);
        wr(4'd5, 8'h03);

        // Held strobe: one capture only, even though the counter changes mid-hold
        @(posedge clk); #1;
        bif.i_cs = 1'b1; bif.i_stb = 1'b1; bif.i_we = 1'b0; bif.i_addr = 4'd8;
        @(posedge clk); #1;
        chk("hold_ready0", {31'd0, bif.o_data_ready}, 32'd1);
        chk("hold_data0", {24'd0, bif.o_data}, 32'h00);
        hcount = 10'd639; vcount = 9'd479;
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 9'd0;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("hold_ready%0d", i), {31'd0, bif.o_data_ready}, 32'd1);
            chk($sformatf("hold_data%0d", i), {24'd0, bif.o_data}, 32'h00);
            @(posedge clk); #1;
        end
        bif.i_stb = 1'b0; bif.i_cs = 1'b0;
        @(posedge clk); #1;
        chk("hold_ready_drop", {31'd0, bif.o_data_ready}, 32'd0);
        rd_chk("hold_frame_l", 4'd8, 8'h01);

        // Not selected: no write, no ready
        bus(1'b1, 4'd10, 8'h77, -1, 1'b0, rd, ir);
        rd_chk("nocs_scratch", 4'd10, 8'hA5);

        // Reset in the middle of a transaction
        @(posedge clk); #1;
        bif.i_cs = 1'b1; bif.i_stb = 1'b1; bif.i_we = 1'b1; bif.i_addr = 4'd10; bif.i_data = 8'h11;
        @(posedge clk); #1;
        chk("mid_ready", {31'd0, bif.o_data_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_ready", {31'd0, bif.o_data_ready}, 32'd0);
        chk("async_fg", {20'd0, fg}, 32'hFFF);
        chk("async_bg", {20'd0, bg}, 32'h000);
        bif.i_stb = 1'b0; bif.i_cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, bif.o_data_ready}, 32'd0);
        rd_chk("post_rst_scratch", 4'd10, 8'h00);

        // Random traffic against the transaction-level model
        m_sh_fg = 12'hFFF; m_live_fg = 12'hFFF; m_sh_bg = 12'h000; m_live_bg = 12'h000;
        m_ctrl = 3'd0; m_vp = 1'b0; m_lp = 1'b0; m_lcmp = 9'd0;
        m_frame = 16'd0; m_snap = 8'h00; m_scr = 8'h00;
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (op < 5) begin
                wr(a, d);
                m_write(a, d);
                chk("rnd_irq_w", {31'd0, irq}, {31'd0, (m_vp & m_ctrl[0]) | (m_lp & m_ctrl[1])});
            end else if (op < 8) begin
                bus(1'b0, a, 8'h00, -1, 1'b1, rd, ir);
                chk($sformatf("rnd_rd_a%0d", a), {24'd0, rd}, {24'd0, m_read(a)});
                if (a == 4'd8) m_snap = m_frame[15:8];
                chk("rnd_irq_r", {31'd0, irq}, {31'd0, (m_vp & m_ctrl[0]) | (m_lp & m_ctrl[1])});
            end else begin
                pulse_frame();
                m_frame++;
                m_live_fg = m_sh_fg;
                m_live_bg = m_sh_bg;
                m_vp = 1'b1;
                if (m_lcmp == 9'd479) m_lp = 1'b1;
            end
            chk("rnd_fg", {20'd0, fg}, {20'd0, m_live_fg});
            chk("rnd_bg", {20'd0, bg}, {20'd0, m_live_bg});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
